// File: rtl/oflow_frame_scheduler_if.sv
// Channel-side bundle between the frame scheduler and the parallel ID-assignment lanes.
// master = scheduler (drives dispatch), slave = channel array (drives ready and results).
interface oflow_frame_scheduler_if #(
  parameter int BBOX_W = 64,
  parameter int NUM_CH = 4,
  parameter int ID_W   = 12
);
  logic [NUM_CH-1:0]        ch_valid;
  logic [BBOX_W*NUM_CH-1:0] ch_bbox;
  logic                     ch_ready;
  logic [NUM_CH-1:0]        res_valid;
  logic [ID_W*NUM_CH-1:0]   res_id;
  logic [NUM_CH-1:0]        res_conflict;

  modport master (
    output ch_valid, ch_bbox,
    input  ch_ready, res_valid, res_id, res_conflict
  );

  modport slave (
    input  ch_valid, ch_bbox,
    output ch_ready, res_valid, res_id, res_conflict
  );
endinterface

// File: rtl/oflow_frame_scheduler.sv
// Frame scheduler: dispatches a frame of bboxes to NUM_CH lanes in batches, collects
// per-lane IDs in any order, counts conflicts against a threshold and flags frame completion.
//   state      | meaning
//   S_IDLE     | waiting for start; frame inputs latched on start
//   S_DISPATCH | batch at base b presented on ch_valid/ch_bbox until ch_ready
//   S_WAIT     | collecting results for the pending lanes of the batch
//   S_DONE     | one-cycle completion pulse, frame counter advances
module oflow_frame_scheduler #(
  parameter int BBOX_W     = 64,
  parameter int MAX_BBOXES = 32,
  parameter int NUM_CH     = 4,
  parameter int ID_W       = 12,
  parameter int CNT_W      = $clog2(MAX_BBOXES + 1)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         i_start,
  input  logic [CNT_W-1:0]             i_bbox_count,
  input  logic [BBOX_W*MAX_BBOXES-1:0] i_bboxes,
  input  logic [4:0]                   i_th_conflict_counter,
  oflow_frame_scheduler_if.master      ch,
  output logic [ID_W*MAX_BBOXES-1:0]   o_ids,
  output logic [MAX_BBOXES-1:0]        o_ids_valid,
  output logic                         o_busy,
  output logic                         o_done_frame,
  output logic [15:0]                  o_frame_num,
  output logic                         o_conflict_overflow
);

  // base can run one batch past the last slot before the DONE decision
  localparam int BASE_W = $clog2(MAX_BBOXES + NUM_CH + 1);
  localparam int CMP_W  = (CNT_W > 5) ? CNT_W : 5;

  typedef enum logic [1:0] {S_IDLE, S_DISPATCH, S_WAIT, S_DONE} state_t;

  state_t                r_state;
  state_t                w_state_nxt;

  logic [BBOX_W-1:0]     r_bbox [MAX_BBOXES];
  logic [ID_W-1:0]       r_ids  [MAX_BBOXES];
  logic [MAX_BBOXES-1:0] r_ids_valid;
  logic [CNT_W-1:0]      r_n;
  logic [CNT_W-1:0]      r_cnt;
  logic [BASE_W-1:0]     r_base;
  logic [NUM_CH-1:0]     r_pending;
  logic                  r_ovf;
  logic [15:0]           r_frame_num;

  logic [CNT_W-1:0]      w_n_in;
  logic [CNT_W-1:0]      w_conf_inc;
  logic [CNT_W-1:0]      w_cnt_nxt;
  logic [BASE_W-1:0]     w_base_nxt;
  logic [BASE_W-1:0]     w_lane_idx [NUM_CH];
  logic [NUM_CH-1:0]     w_lane_act;
  logic [NUM_CH-1:0]     w_acc;
  logic [15:0]           w_frame_num_nxt;
  logic                  w_start_acc;
  logic                  w_hs;
  logic                  w_batch_done;
  logic                  w_ovf_hit;

  always_comb begin
    w_n_in = i_bbox_count;
    if (i_bbox_count > CNT_W'(MAX_BBOXES)) w_n_in = CNT_W'(MAX_BBOXES);
  end

  always_comb begin
    for (int k = 0; k < NUM_CH; k++) begin
      w_lane_idx[k] = r_base + BASE_W'(k);
      w_lane_act[k] = (w_lane_idx[k] < BASE_W'(r_n));
    end
  end

  assign w_base_nxt = r_base + BASE_W'(NUM_CH);

  always_comb begin
    w_conf_inc = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      w_conf_inc = w_conf_inc + CNT_W'(w_acc[k] & ch.res_conflict[k]);
    end
    w_cnt_nxt = r_cnt + w_conf_inc;
    w_ovf_hit = (CMP_W'(w_cnt_nxt) > CMP_W'(i_th_conflict_counter));
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_start_acc  = 1'b0;
    w_hs         = 1'b0;
    w_batch_done = 1'b0;
    w_acc        = '0;
    ch.ch_valid  = '0;
    ch.ch_bbox   = '0;
    o_busy       = (r_state != S_IDLE);
    o_done_frame = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_start_acc = 1'b1;
          w_state_nxt = (w_n_in == '0) ? S_DONE : S_DISPATCH;
        end
      end
      S_DISPATCH: begin
        ch.ch_valid = w_lane_act;
        for (int k = 0; k < NUM_CH; k++) begin
          for (int j = 0; j < MAX_BBOXES; j++) begin
            if (w_lane_act[k] && (w_lane_idx[k] == BASE_W'(j)))
              ch.ch_bbox[k*BBOX_W +: BBOX_W] = r_bbox[j];
          end
        end
        if ((w_lane_act != '0) && ch.ch_ready) begin
          w_hs        = 1'b1;
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        w_acc = ch.res_valid & r_pending;
        // batch closes in the same cycle its last pending result arrives
        if ((r_pending & ~w_acc) == '0) begin
          w_batch_done = 1'b1;
          w_state_nxt  = (w_base_nxt >= BASE_W'(r_n)) ? S_DONE : S_DISPATCH;
        end
      end
      S_DONE: begin
        o_done_frame = 1'b1;
        w_state_nxt  = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_frame_num_nxt = (r_state == S_DONE) ? r_frame_num + 16'd1 : r_frame_num;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int j = 0; j < MAX_BBOXES; j++) begin
        r_bbox[j] <= '0;
        r_ids[j]  <= '0;
      end
      r_ids_valid <= '0;
      r_n         <= '0;
      r_cnt       <= '0;
      r_base      <= '0;
      r_pending   <= '0;
      r_ovf       <= 1'b0;
      r_frame_num <= '0;
    end else begin
      r_frame_num <= w_frame_num_nxt;
      if (w_start_acc) begin
        for (int j = 0; j < MAX_BBOXES; j++) r_bbox[j] <= i_bboxes[j*BBOX_W +: BBOX_W];
        r_n         <= w_n_in;
        r_cnt       <= '0;
        r_base      <= '0;
        r_pending   <= '0;
        r_ids_valid <= '0;
        r_ovf       <= 1'b0;
      end else begin
        if (w_hs) r_pending <= w_lane_act;
        if (r_state == S_WAIT) begin
          r_pending <= r_pending & ~w_acc;
          r_cnt     <= w_cnt_nxt;
        end
        if (w_batch_done) r_base <= w_base_nxt;
        for (int j = 0; j < MAX_BBOXES; j++) begin
          for (int k = 0; k < NUM_CH; k++) begin
            if (w_acc[k] && (w_lane_idx[k] == BASE_W'(j))) begin
              r_ids[j]       <= ch.res_id[k*ID_W +: ID_W];
              r_ids_valid[j] <= 1'b1;
            end
          end
        end
        // threshold is live, so re-evaluate every cycle; flag stays sticky
        r_ovf <= r_ovf | w_ovf_hit;
      end
    end
  end

  always_comb begin
    o_ids = '0;
    for (int j = 0; j < MAX_BBOXES; j++) o_ids[j*ID_W +: ID_W] = r_ids[j];
  end

  assign o_ids_valid         = r_ids_valid;
  assign o_frame_num         = r_frame_num;
  assign o_conflict_overflow = r_ovf;

endmodule

// File: tb/tb_oflow_frame_scheduler.sv
// Directed bench for oflow_frame_scheduler: inputs driven and outputs sampled on the
// falling edge, so each step() lands mid-cycle of the next DUT cycle.
module tb_oflow_frame_scheduler;
  localparam int BBOX_W = 64;
  localparam int MAX_B  = 32;
  localparam int NUM_CH = 4;
  localparam int ID_W   = 12;
  localparam int CNT_W  = 6;

  logic                    clk = 1'b0;
  logic                    reset;
  logic                    start;
  logic [CNT_W-1:0]        bbox_count;
  logic [BBOX_W*MAX_B-1:0] bboxes;
  logic [4:0]              th;
  logic [ID_W*MAX_B-1:0]   o_ids;
  logic [MAX_B-1:0]        o_ids_valid;
  logic                    o_busy;
  logic                    o_done_frame;
  logic [15:0]             o_frame_num;
  logic                    o_conflict_overflow;

  int n_tests = 0;
  int n_fail  = 0;
  int n_done  = 0;

  always #5 clk = ~clk;

  oflow_frame_scheduler_if #(.BBOX_W(BBOX_W), .NUM_CH(NUM_CH), .ID_W(ID_W)) ch_if ();

  oflow_frame_scheduler #(
    .BBOX_W(BBOX_W), .MAX_BBOXES(MAX_B), .NUM_CH(NUM_CH), .ID_W(ID_W), .CNT_W(CNT_W)
  ) dut (
    .clk                   (clk),
    .reset                 (reset),
    .i_start               (start),
    .i_bbox_count          (bbox_count),
    .i_bboxes              (bboxes),
    .i_th_conflict_counter (th),
    .ch                    (ch_if.master),
    .o_ids                 (o_ids),
    .o_ids_valid           (o_ids_valid),
    .o_busy                (o_busy),
    .o_done_frame          (o_done_frame),
    .o_frame_num           (o_frame_num),
    .o_conflict_overflow   (o_conflict_overflow)
  );

  always @(posedge clk) if (o_done_frame === 1'b1) n_done <= n_done + 1;

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  function automatic logic [ID_W-1:0] id_at(input int j);
    return o_ids[j*ID_W +: ID_W];
  endfunction

  task automatic fill_bboxes(input logic [63:0] base);
    for (int j = 0; j < MAX_B; j++) bboxes[j*BBOX_W +: BBOX_W] = base + 64'(j);
  endtask

  // Start a frame, accept every batch at once and return ID id_base+slot one cycle later.
  // Returns positioned in the cycle where DONE is expected.
  task automatic run_std(input int cnt, input int n_eff, input int id_base);
    logic [NUM_CH-1:0] m;
    start = 1'b1; bbox_count = CNT_W'(cnt); ch_if.ch_ready = 1'b1;
    step();
    start = 1'b0;
    for (int b = 0; b < n_eff; b += NUM_CH) begin
      for (int k = 0; k < NUM_CH; k++) m[k] = (b + k < n_eff);
      check_val($sformatf("std_valid_b%0d", b), 64'(ch_if.ch_valid), 64'(m));
      check_val($sformatf("std_bbox_b%0d", b), ch_if.ch_bbox[0 +: BBOX_W], bboxes[b*BBOX_W +: BBOX_W]);
      step();
      check_val($sformatf("std_wait_valid_b%0d", b), 64'(ch_if.ch_valid), 64'd0);
      ch_if.res_valid = m;
      for (int k = 0; k < NUM_CH; k++) ch_if.res_id[k*ID_W +: ID_W] = ID_W'(id_base + b + k);
      step();
      ch_if.res_valid = '0;
    end
    check_val($sformatf("std_done_n%0d", cnt), 64'(o_done_frame), 64'd1);
    ch_if.ch_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; start = 1'b0; bbox_count = '0; bboxes = '0; th = 5'd31;
    ch_if.ch_ready = 1'b0; ch_if.res_valid = '0; ch_if.res_id = '0; ch_if.res_conflict = '0;
    step(); step();
    check_val("rst_busy",      64'(o_busy), 64'd0);
    check_val("rst_done",      64'(o_done_frame), 64'd0);
    check_val("rst_ch_valid",  64'(ch_if.ch_valid), 64'd0);
    check_val("rst_ids_valid", 64'(o_ids_valid), 64'd0);
    check_val("rst_ids",       64'(|o_ids), 64'd0);
    check_val("rst_frame_num", 64'(o_frame_num), 64'd0);
    check_val("rst_ovf",       64'(o_conflict_overflow), 64'd0);
    reset = 1'b0;
    step();

    // basic frame: n=10, three batches, last batch lanes 0-1 only
    fill_bboxes(64'hB0B0_0000_0000_0000);
    run_std(10, 10, 100);
    check_val("basic_ids_valid", 64'(o_ids_valid), 64'h3FF);
    for (int j = 0; j < 10; j++) check_val($sformatf("basic_id%0d", j), 64'(id_at(j)), 64'(100 + j));
    check_val("basic_id10_untouched", 64'(id_at(10)), 64'd0);
    check_val("basic_fnum_in_done", 64'(o_frame_num), 64'd0);
    step();
    check_val("basic_done_pulse", 64'(o_done_frame), 64'd0);
    check_val("basic_busy_idle",  64'(o_busy), 64'd0);
    check_val("basic_fnum",       64'(o_frame_num), 64'd1);
    check_val("basic_done_cnt",   64'(n_done), 64'd1);

    // out-of-order returns with 5 cycles of backpressure and a duplicate on lane 3
    fill_bboxes(64'hC0C0_0000_0000_0000);
    start = 1'b1; bbox_count = 6'd4; ch_if.ch_ready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      step();
      start = 1'b0;
      check_val($sformatf("ooo_hold_valid%0d", i), 64'(ch_if.ch_valid), 64'hF);
      check_val($sformatf("ooo_hold_l0_%0d", i), ch_if.ch_bbox[0 +: BBOX_W], 64'hC0C0_0000_0000_0000);
      check_val($sformatf("ooo_hold_l3_%0d", i), ch_if.ch_bbox[3*BBOX_W +: BBOX_W], 64'hC0C0_0000_0000_0003);
    end
    step();
    check_val("ooo_still_dispatch", 64'(ch_if.ch_valid), 64'hF);
    ch_if.ch_ready = 1'b1;
    step();
    ch_if.ch_ready = 1'b0;
    check_val("ooo_wait_valid", 64'(ch_if.ch_valid), 64'd0);
    ch_if.res_valid = 4'b1000; ch_if.res_id = {12'd203, 12'd0, 12'd0, 12'd0};
    step();
    check_val("ooo_not_done_a", 64'(o_done_frame), 64'd0);
    ch_if.res_valid = 4'b0001; ch_if.res_id = {12'd0, 12'd0, 12'd0, 12'd200};
    step();
    check_val("ooo_not_done_b", 64'(o_done_frame), 64'd0);
    ch_if.res_valid = 4'b1100; ch_if.res_id = {12'd999, 12'd202, 12'd0, 12'd0};
    step();
    check_val("ooo_not_done_c", 64'(o_done_frame), 64'd0);
    ch_if.res_valid = 4'b0010; ch_if.res_id = {12'd0, 12'd0, 12'd201, 12'd0};
    step();
    ch_if.res_valid = '0;
    check_val("ooo_done",      64'(o_done_frame), 64'd1);
    check_val("ooo_ids_valid", 64'(o_ids_valid), 64'hF);
    check_val("ooo_id0",       64'(id_at(0)), 64'd200);
    check_val("ooo_id1",       64'(id_at(1)), 64'd201);
    check_val("ooo_id2",       64'(id_at(2)), 64'd202);
    check_val("ooo_id3_nodup", 64'(id_at(3)), 64'd203);
    check_val("ooo_id4_held",  64'(id_at(4)), 64'd104);
    step();
    check_val("ooo_fnum", 64'(o_frame_num), 64'd2);

    // empty frame: DONE the cycle after start
    run_std(0, 0, 0);
    check_val("empty_busy",      64'(o_busy), 64'd1);
    check_val("empty_ids_valid", 64'(o_ids_valid), 64'd0);
    step();
    check_val("empty_fnum",     64'(o_frame_num), 64'd3);
    check_val("empty_done_cnt", 64'(n_done), 64'd3);

    // clamped frame: 40 requested, 32 slots, DONE right after the 8th batch
    fill_bboxes(64'hD0D0_0000_0000_0000);
    run_std(40, 32, 300);
    check_val("clamp_ids_valid", 64'(o_ids_valid), 64'hFFFF_FFFF);
    check_val("clamp_id0",       64'(id_at(0)), 64'd300);
    check_val("clamp_id31",      64'(id_at(31)), 64'd331);
    step();
    check_val("clamp_fnum", 64'(o_frame_num), 64'd4);

    // conflict threshold 2, three conflicting results
    th = 5'd2;
    start = 1'b1; bbox_count = 6'd4; ch_if.ch_ready = 1'b1;
    step();
    start = 1'b0;
    step();
    ch_if.ch_ready = 1'b0;
    ch_if.res_valid = 4'b0001; ch_if.res_conflict = 4'b0001;
    step();
    ch_if.res_valid = 4'b0010; ch_if.res_conflict = 4'b0010;
    step();
    check_val("cfl_ovf_before_third", 64'(o_conflict_overflow), 64'd0);
    ch_if.res_valid = 4'b0100; ch_if.res_conflict = 4'b0100;
    step();
    check_val("cfl_ovf_rises", 64'(o_conflict_overflow), 64'd1);
    ch_if.res_valid = 4'b1000; ch_if.res_conflict = 4'b0000;
    step();
    ch_if.res_valid = '0;
    check_val("cfl_done",     64'(o_done_frame), 64'd1);
    check_val("cfl_ovf_done", 64'(o_conflict_overflow), 64'd1);
    step();
    check_val("cfl_ovf_idle", 64'(o_conflict_overflow), 64'd1);
    check_val("cfl_fnum",     64'(o_frame_num), 64'd5);

    // robustness: start in WAIT ignored, reset mid-WAIT aborts without done_frame
    start = 1'b1; bbox_count = 6'd4; ch_if.ch_ready = 1'b1;
    step();
    start = 1'b0;
    check_val("rob_ovf_cleared", 64'(o_conflict_overflow), 64'd0);
    step();
    ch_if.ch_ready = 1'b0;
    start = 1'b1; bbox_count = 6'd1;
    ch_if.res_valid = 4'b0011; ch_if.res_id = {12'd0, 12'd0, 12'd601, 12'd600};
    step();
    start = 1'b0; ch_if.res_valid = '0;
    check_val("rob_still_wait_valid", 64'(ch_if.ch_valid), 64'd0);
    check_val("rob_still_busy",       64'(o_busy), 64'd1);
    check_val("rob_ids_valid_kept",   64'(o_ids_valid), 64'h3);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_val("rob_rst_busy",      64'(o_busy), 64'd0);
    check_val("rob_rst_done",      64'(o_done_frame), 64'd0);
    check_val("rob_rst_ids_valid", 64'(o_ids_valid), 64'd0);
    check_val("rob_rst_ids",       64'(|o_ids), 64'd0);
    check_val("rob_rst_fnum",      64'(o_frame_num), 64'd0);
    check_val("rob_rst_ovf",       64'(o_conflict_overflow), 64'd0);
    check_val("rob_no_done",       64'(n_done), 64'd5);
    fill_bboxes(64'hE0E0_0000_0000_0000);
    run_std(5, 5, 400);
    check_val("rob_ids_valid", 64'(o_ids_valid), 64'h1F);
    check_val("rob_id4",       64'(id_at(4)), 64'd404);
    step();
    check_val("rob_fnum", 64'(o_frame_num), 64'd1);

    // wrap: counter preloaded close to the top, then empty frames carry it over
    force dut.r_frame_num = 16'hFFFD;
    step();
    release dut.r_frame_num;
    check_val("wrap_preload", 64'(o_frame_num), 64'hFFFD);
    run_std(0, 0, 0);
    step();
    check_val("wrap_fffe", 64'(o_frame_num), 64'hFFFE);
    run_std(0, 0, 0);
    step();
    check_val("wrap_ffff", 64'(o_frame_num), 64'hFFFF);
    run_std(0, 0, 0);
    step();
    check_val("wrap_zero", 64'(o_frame_num), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
